// File: rtl/nonblocking_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nonblocking_pkg
//  Purpose  : Shared definitions for the four-register non-blocking update
//             datapath: checker state encoding, field indices of the
//             mismatch vector and the default recurrence constants (also
//             used by the producer).
//  Revision : 1.0  initial release
// ============================================================================
package nonblocking_pkg;

    // Checker state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_t;

    // Bit positions inside the mismatch vector, {d,c,b,a}
    localparam int FLD_A = 0;
    localparam int FLD_B = 1;
    localparam int FLD_C = 2;
    localparam int FLD_D = 3;

    // Recurrence constants shared with the producer
    localparam int DEF_A_SUB = 3;
    localparam int DEF_B_ADD = 10;
    localparam int DEF_C_INC = 1;

endpackage
`default_nettype wire

// File: rtl/nonblocking_predict.sv
`default_nettype none
// ============================================================================
//  Module   : nonblocking_predict
//  Purpose  : Combinational next-sample prediction for the four-register
//             non-blocking update recurrence (all arithmetic mod 2^WIDTH):
//               exp_a = prev_b + prev_c
//               exp_b = prev_d + B_ADD
//               exp_c = prev_c + C_INC
//               exp_d = prev_a - A_SUB
//  Ports    : i_prev_a..i_prev_d  in  WIDTH  previous sample
//             o_exp_a..o_exp_d    out WIDTH  predicted next sample
//  Revision : 1.0  initial release
// ============================================================================
module nonblocking_predict
    import nonblocking_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int A_SUB = DEF_A_SUB,
    parameter int B_ADD = DEF_B_ADD,
    parameter int C_INC = DEF_C_INC
) (
    input  logic [WIDTH-1:0] i_prev_a,
    input  logic [WIDTH-1:0] i_prev_b,
    input  logic [WIDTH-1:0] i_prev_c,
    input  logic [WIDTH-1:0] i_prev_d,
    output logic [WIDTH-1:0] o_exp_a,
    output logic [WIDTH-1:0] o_exp_b,
    output logic [WIDTH-1:0] o_exp_c,
    output logic [WIDTH-1:0] o_exp_d
);

    // Constants truncated to the datapath width so every sum wraps naturally
    localparam logic [WIDTH-1:0] C_A_SUB = WIDTH'(A_SUB);
    localparam logic [WIDTH-1:0] C_B_ADD = WIDTH'(B_ADD);
    localparam logic [WIDTH-1:0] C_C_INC = WIDTH'(C_INC);

    assign o_exp_a = i_prev_b + i_prev_c;
    assign o_exp_b = i_prev_d + C_B_ADD;
    assign o_exp_c = i_prev_c + C_C_INC;
    assign o_exp_d = i_prev_a - C_A_SUB;

endmodule
`default_nettype wire

// File: rtl/nonblocking_checker.sv
`default_nettype none
// ============================================================================
//  Module   : nonblocking_checker
//  Purpose  : Consumer-side self-check for the four-register non-blocking
//             update datapath. The first valid sample after start primes the
//             reference; every later valid sample is compared against the
//             prediction made from the previously observed sample.
//  Ports    : clock          in   1      rising-edge clock
//             reset_n        in   1      asynchronous active-low reset
//             start          in   1      arm / restart pulse
//             valid          in   1      a/b/c/d carry a producer sample
//             a_in..d_in     in   WIDTH  producer registers
//             locked         out  1      reference held, checking active
//             mismatch       out  4      last checked sample errors {d,c,b,a}
//             err            out  1      sticky error since last start
//             err_count      out  CNT_W  mismatching samples (saturating)
//             sample_idx     out  CNT_W  current sample index (saturating)
//             first_err_idx  out  CNT_W  index of first mismatching sample
//  Revision : 1.0  initial release
// ============================================================================
module nonblocking_checker
    import nonblocking_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int A_SUB       = DEF_A_SUB,
    parameter int B_ADD       = DEF_B_ADD,
    parameter int C_INC       = DEF_C_INC,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             locked,
    output logic [3:0]       mismatch,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_idx,
    output logic [CNT_W-1:0] first_err_idx
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_prev_a, r_prev_b, r_prev_c, r_prev_d;
    logic [3:0]       r_mismatch;
    logic             r_err;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_sample_idx;
    logic [CNT_W-1:0] r_first_err_idx;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_prev_a_nxt, w_prev_b_nxt, w_prev_c_nxt, w_prev_d_nxt;
    logic [3:0]       w_mismatch_nxt;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_err_count_nxt;
    logic [CNT_W-1:0] w_sample_idx_nxt;
    logic [CNT_W-1:0] w_first_err_idx_nxt;

    // ------------------------------------------------------------------
    // Prediction and field compare
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_exp_a, w_exp_b, w_exp_c, w_exp_d;
    logic [3:0]       w_cmp;
    logic [CNT_W-1:0] w_idx_inc;
    logic [CNT_W-1:0] w_cnt_inc;

    nonblocking_predict #(
        .WIDTH (WIDTH),
        .A_SUB (A_SUB),
        .B_ADD (B_ADD),
        .C_INC (C_INC)
    ) u_predict (
        .i_prev_a (r_prev_a),
        .i_prev_b (r_prev_b),
        .i_prev_c (r_prev_c),
        .i_prev_d (r_prev_d),
        .o_exp_a  (w_exp_a),
        .o_exp_b  (w_exp_b),
        .o_exp_c  (w_exp_c),
        .o_exp_d  (w_exp_d)
    );

    assign w_cmp[FLD_A] = (a_in != w_exp_a);
    assign w_cmp[FLD_B] = (b_in != w_exp_b);
    assign w_cmp[FLD_C] = (c_in != w_exp_c);
    assign w_cmp[FLD_D] = (d_in != w_exp_d);

    // Saturating increments: counters stick at all-ones
    assign w_idx_inc = (&r_sample_idx) ? r_sample_idx : r_sample_idx + CNT_W'(1);
    assign w_cnt_inc = (&r_err_count)  ? r_err_count  : r_err_count  + CNT_W'(1);

    // ------------------------------------------------------------------
    // Next-state / bookkeeping logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt         = r_state;
        w_prev_a_nxt        = r_prev_a;
        w_prev_b_nxt        = r_prev_b;
        w_prev_c_nxt        = r_prev_c;
        w_prev_d_nxt        = r_prev_d;
        w_mismatch_nxt      = r_mismatch;
        w_err_nxt           = r_err;
        w_err_count_nxt     = r_err_count;
        w_sample_idx_nxt    = r_sample_idx;
        w_first_err_idx_nxt = r_first_err_idx;

        if (start) begin
            // Arm or restart from any state; a same-cycle valid is dropped
            w_state_nxt         = PRIME;
            w_mismatch_nxt      = 4'd0;
            w_err_nxt           = 1'b0;
            w_err_count_nxt     = '0;
            w_sample_idx_nxt    = '0;
            w_first_err_idx_nxt = '0;
        end else if (valid) begin
            case (r_state)
                PRIME: begin
                    w_prev_a_nxt = a_in;
                    w_prev_b_nxt = b_in;
                    w_prev_c_nxt = c_in;
                    w_prev_d_nxt = d_in;
                    w_state_nxt  = CHECK;
                end
                CHECK: begin
                    w_mismatch_nxt   = w_cmp;
                    w_sample_idx_nxt = w_idx_inc;
                    // Resync on observed data so a glitch costs one sample
                    w_prev_a_nxt     = a_in;
                    w_prev_b_nxt     = b_in;
                    w_prev_c_nxt     = c_in;
                    w_prev_d_nxt     = d_in;
                    if (|w_cmp) begin
                        w_err_nxt       = 1'b1;
                        w_err_count_nxt = w_cnt_inc;
                        if (!r_err) begin
                            w_first_err_idx_nxt = w_idx_inc;
                        end
                        if (STOP_ON_ERR) begin
                            w_state_nxt = FAIL;
                        end
                    end
                end
                default: begin
                    // IDLE and FAIL ignore valid
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_prev_a        <= '0;
            r_prev_b        <= '0;
            r_prev_c        <= '0;
            r_prev_d        <= '0;
            r_mismatch      <= 4'd0;
            r_err           <= 1'b0;
            r_err_count     <= '0;
            r_sample_idx    <= '0;
            r_first_err_idx <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_prev_a        <= w_prev_a_nxt;
            r_prev_b        <= w_prev_b_nxt;
            r_prev_c        <= w_prev_c_nxt;
            r_prev_d        <= w_prev_d_nxt;
            r_mismatch      <= w_mismatch_nxt;
            r_err           <= w_err_nxt;
            r_err_count     <= w_err_count_nxt;
            r_sample_idx    <= w_sample_idx_nxt;
            r_first_err_idx <= w_first_err_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign locked        = (r_state == CHECK);
    assign mismatch      = r_mismatch;
    assign err           = r_err;
    assign err_count     = r_err_count;
    assign sample_idx    = r_sample_idx;
    assign first_err_idx = r_first_err_idx;

endmodule
`default_nettype wire

// File: doc/nonblocking_checker.md
Name: nonblocking_checker

Overview:
- Consumer-side block for the four-register non-blocking update datapath.
- Samples the producer's a/b/c/d outputs once per valid clock and checks that each new sample follows from the previous sample under the update recurrence.
- Reports lock, per-field mismatch flags, an error count and the index of the first failing sample.
- Sits beside the producer in simulation and FPGA bring-up as a hardware self-check.

Parameters:
- WIDTH, 32, datapath width; all arithmetic is modulo 2^WIDTH.
- A_SUB, 3, constant subtracted: exp_d = prev_a - A_SUB.
- B_ADD, 10, constant added: exp_b = prev_d + B_ADD.
- C_INC, 1, increment: exp_c = prev_c + C_INC.
- CNT_W, 16, width of the sample and error counters.
- STOP_ON_ERR, 0, 1 = enter FAIL on the first mismatch and stop checking.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; arms the checker from IDLE or FAIL.
- valid  in  1  a/b/c/d carry a new producer sample this cycle.
- a_in  in  WIDTH  producer register a.
- b_in  in  WIDTH  producer register b.
- c_in  in  WIDTH  producer register c.
- d_in  in  WIDTH  producer register d.
- locked  out  1  a reference sample is held and checking is active.
- mismatch  out  4  per-field error for the last checked sample, bit order {d,c,b,a}.
- err  out  1  sticky; any mismatch since the last start.
- err_count  out  CNT_W  number of checked samples with any mismatch; saturates.
- sample_idx  out  CNT_W  index of the current sample (0 = priming sample); saturates.
- first_err_idx  out  CNT_W  sample_idx of the first mismatching sample.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - All outputs, prev_a..prev_d and counters go to 0.
  - Reset asserted mid-check discards everything immediately.
- States:
  - IDLE: valid is ignored. start -> PRIME; this clears err, err_count, sample_idx, first_err_idx and mismatch.
  - PRIME: the first valid captures a/b/c/d into prev_*, no compare, sample_idx stays 0, -> CHECK. locked rises the cycle after capture.
  - CHECK: on each valid:
    - exp_a = prev_b + prev_c; exp_b = prev_d + B_ADD; exp_c = prev_c + C_INC; exp_d = prev_a - A_SUB.
    - Compare each exp_* to its input. Registered mismatch[] updates one cycle after valid and is held until the next valid.
    - sample_idx increments.
    - prev_* load the observed inputs, not the expected values, so a single glitch yields one error sample and a resync.
  - FAIL: only reachable when STOP_ON_ERR = 1, on the first mismatch. locked = 0; outputs are frozen; valid is ignored; start -> PRIME.
- Mismatch bookkeeping:
  - Any mismatch bit set: err <= 1 (sticky); err_count += 1 (saturating at all-ones).
  - If this is the first error since start, first_err_idx <= sample_idx of that sample.
- Arithmetic: WIDTH-bit wraparound, no carry out. prev_a = 0 gives exp_d = 2^WIDTH - A_SUB; all-ones + 1 wraps to 0.
- start asserted in PRIME or CHECK is a restart: clear as from IDLE, -> PRIME, and any same-cycle valid is dropped.
- valid low: no state change. Gaps of any length between samples are allowed.
- Latency: mismatch, err and err_count are visible one clock after the sampled valid edge.

Decomposition:
- Package nonblocking_pkg:
  - state enum {IDLE, PRIME, CHECK, FAIL}.
  - Field index constants FLD_A = 0, FLD_B = 1, FLD_C = 2, FLD_D = 3.
  - Default A_SUB, B_ADD and C_INC values, shared with the producer.
- One sub-module, nonblocking_predict: a purely combinational computation of exp_a..exp_d from prev_*. It is reused by the producer-model testbench.

Test Plan:
- Clean run: start, then valid samples (30,20,15,5), (35,15,16,27), (31,37,17,32) -> locked = 1, mismatch = 0 throughout, err = 0, sample_idx = 2.
- Corrupted field: after priming with (30,20,15,5), feed (35,15,16,28) -> mismatch = 4'b1000, err = 1, err_count = 1, first_err_idx = 1. The next sample, predicted from the observed data, checks clean.
- Wraparound: prime with (0,0xFFFFFFFF,0xFFFFFFFF,0xFFFFFFF6), then feed (0xFFFFFFFE,0,0,0xFFFFFFFD) -> no mismatch.
- STOP_ON_ERR = 1: inject a bad b -> state FAIL, locked = 0, subsequent valids are ignored and err_count stays 1. start re-primes.
- Reset mid-check: drop reset_n asynchronously, between clock edges, during CHECK -> every output is 0 immediately. valid with no start leaves the block in IDLE.
- Gapped valid plus restart: hold valid low for 5 cycles between samples -> no errors. A start pulse during CHECK clears the counters and re-primes on the next valid.
